// File: rtl/input_memory_node.sv
// Input memory node: streams a contiguous block of 32-bit words from OBI
// memory into a CGRA input port through a credit-limited read buffer.
package imn_pkg;
  typedef struct packed {
    logic        req;
    logic        we;
    logic [3:0]  be;
    logic [31:0] addr;
    logic [31:0] wdata;
  } obi_req_t;

  typedef struct packed {
    logic        gnt;
    logic        rvalid;
    logic [31:0] rdata;
  } obi_resp_t;
endpackage

module input_memory_node
  import imn_pkg::*;
#(
  parameter int FIFO_DEPTH = 8
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        clr_i,
  output obi_req_t    masters_req_o,
  input  obi_resp_t   masters_resp_i,
  input  logic [31:0] imn_addr_i,
  input  logic [15:0] imn_size_i,
  input  logic        exec_i,
  output logic        done_o,
  output logic [31:0] dout_o,
  output logic        dout_v_o,
  input  logic        dout_r_i
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW:0] DEPTH_C = (CW+1)'(FIFO_DEPTH);

  typedef enum logic [1:0] {
    S_IDLE,
    S_MREQ,
    S_DRAIN,
    S_DONE
  } state_t;

  state_t         r_state;
  state_t         w_next;
  logic [15:0]    r_offset;
  logic [CW-1:0]  r_out;
  logic [AW:0]    r_wptr;
  logic [AW:0]    r_rptr;
  logic [31:0]    r_mem [FIFO_DEPTH];

  logic [CW-1:0]  w_usage;
  logic [CW:0]    w_used;
  logic           w_empty;
  logic           w_req;
  logic           w_grant;
  logic           w_push;
  logic           w_pop;
  logic           w_last;

  assign w_usage = r_wptr - r_rptr;
  assign w_empty = (w_usage == '0);
  // Words in flight plus words buffered never exceed the buffer depth.
  assign w_used  = {1'b0, r_out} + {1'b0, w_usage};
  assign w_grant = w_req & masters_resp_i.gnt;
  assign w_push  = masters_resp_i.rvalid &
                   ((r_state == S_MREQ) | (r_state == S_DRAIN));
  assign w_pop   = ~w_empty & dout_r_i;
  assign w_last  = ({1'b0, r_offset} + 17'd4) >= {1'b0, imn_size_i};

  always_comb begin
    w_next = r_state;
    w_req  = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        if (exec_i)
          w_next = (imn_size_i == '0) ? S_DONE : S_MREQ;
      end
      S_MREQ: begin
        w_req = (w_used < DEPTH_C);
        if (w_req & masters_resp_i.gnt & w_last)
          w_next = S_DRAIN;
      end
      S_DRAIN: begin
        if ((r_out == '0) && !w_push &&
            (w_empty || (w_usage == CW'(1) && w_pop)))
          w_next = S_DONE;
      end
      S_DONE: w_next = S_DONE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state  <= S_IDLE;
      r_offset <= '0;
      r_out    <= '0;
      r_wptr   <= '0;
      r_rptr   <= '0;
    end else if (clr_i) begin
      r_state  <= S_IDLE;
      r_offset <= '0;
      r_out    <= '0;
      r_wptr   <= '0;
      r_rptr   <= '0;
    end else begin
      r_state <= w_next;
      if (w_grant)
        r_offset <= r_offset + 16'd4;
      unique case ({w_grant, w_push})
        2'b10:   r_out <= r_out + CW'(1);
        2'b01:   r_out <= r_out - CW'(1);
        default: r_out <= r_out;
      endcase
      if (w_push)
        r_wptr <= r_wptr + (AW+1)'(1);
      if (w_pop)
        r_rptr <= r_rptr + (AW+1)'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (w_push && !clr_i)
      r_mem[r_wptr[AW-1:0]] <= masters_resp_i.rdata;
  end

  assign masters_req_o.req   = w_req;
  assign masters_req_o.we    = 1'b0;
  assign masters_req_o.be    = 4'b1111;
  assign masters_req_o.addr  = imn_addr_i + {16'h0, r_offset};
  assign masters_req_o.wdata = '0;

  assign done_o   = (r_state == S_DONE);
  assign dout_v_o = ~w_empty;
  assign dout_o   = r_mem[r_rptr[AW-1:0]];

endmodule

// File: tb/tb_input_memory_node.sv
// Directed bench for input_memory_node with a one-cycle-latency
// OBI memory model and hand-computed expectations.
module tb_input_memory_node;
  import imn_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        clr = 1'b0;
  obi_req_t    req;
  obi_resp_t   resp;
  logic [31:0] base = '0;
  logic [15:0] size = '0;
  logic        exec = 1'b0;
  logic        done;
  logic [31:0] dout;
  logic        dout_v;
  logic        dout_r = 1'b0;

  logic        tb_gnt = 1'b0;
  logic        tb_rv = 1'b0;
  logic [31:0] tb_rd = '0;

  int          total = 0;
  int          bad = 0;
  int          gcnt = 0;
  int          rq_cycles = 0;
  logic [31:0] gaddr [$];
  logic [31:0] pops [$];

  assign resp.gnt    = tb_gnt;
  assign resp.rvalid = tb_rv;
  assign resp.rdata  = tb_rd;

  input_memory_node #(.FIFO_DEPTH(8)) dut (
    .clk_i         (clk),
    .rst_ni        (rst_n),
    .clr_i         (clr),
    .masters_req_o (req),
    .masters_resp_i(resp),
    .imn_addr_i    (base),
    .imn_size_i    (size),
    .exec_i        (exec),
    .done_o        (done),
    .dout_o        (dout),
    .dout_v_o      (dout_v),
    .dout_r_i      (dout_r)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mdata(logic [31:0] a);
    return a ^ 32'hDEAD_0000;
  endfunction

  // memory model: answers each grant one cycle later
  initial begin
    logic        g;
    logic [31:0] a;
    forever begin
      @(posedge clk);
      g = req.req & tb_gnt;
      a = req.addr;
      if (g) begin
        gcnt++;
        gaddr.push_back(a);
      end
      if (req.req) rq_cycles++;
      if (dout_v & dout_r) pops.push_back(dout);
      #1;
      tb_rv = g;
      tb_rd = g ? mdata(a) : 32'h0;
    end
  end

  task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", tag, got, exp);
    end
  endtask

  task automatic cyc(int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic clr_stats();
    gcnt = 0;
    rq_cycles = 0;
    gaddr.delete();
    pops.delete();
  endtask

  task automatic do_clr();
    clr = 1'b1;
    cyc(1);
    clr = 1'b0;
    cyc(1);
    clr_stats();
  endtask

  task automatic start(logic [31:0] a, logic [15:0] s);
    base = a;
    size = s;
    exec = 1'b1;
    cyc(1);
    exec = 1'b0;
  endtask

  task automatic wait_done(int n);
    int k = 0;
    while (!done && k < n) begin
      cyc(1);
      k++;
    end
    check("done_wait", 32'(done), 32'd1);
  endtask

  initial begin
    cyc(2);
    check("rst_req", 32'(req.req), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_dv", 32'(dout_v), 32'd0);
    rst_n = 1'b1;
    cyc(1);
    check("idle_we_be", {27'd0, req.we, req.be}, 32'h0000_000F);
    check("idle_wdata", req.wdata, 32'h0);
    clr_stats();

    // basic 4-word stream
    tb_gnt = 1'b1;
    dout_r = 1'b1;
    start(32'h1000, 16'd16);
    wait_done(50);
    check("s1_gcnt", gcnt, 4);
    for (int i = 0; i < 4; i++) begin
      check("s1_addr", (i < gaddr.size()) ? gaddr[i] : 32'hX,
            32'h1000 + 32'(4 * i));
      check("s1_data", (i < pops.size()) ? pops[i] : 32'hX,
            mdata(32'h1000 + 32'(4 * i)));
    end
    check("s1_npop", pops.size(), 4);
    cyc(2);
    check("s1_done_hold", 32'(done), 32'd1);
    check("s1_req_off", 32'(req.req), 32'd0);
    do_clr();
    check("clr_done", 32'(done), 32'd0);

    // zero-length stream
    start(32'h1000, 16'd0);
    cyc(1);
    check("s0_done", 32'(done), 32'd1);
    check("s0_rq", rq_cycles, 0);
    do_clr();

    // back-pressure limits requests to the buffer depth
    dout_r = 1'b0;
    start(32'h5000, 16'd64);
    cyc(20);
    check("bp_gcnt", gcnt, 8);
    check("bp_req", 32'(req.req), 32'd0);
    check("bp_dv", 32'(dout_v), 32'd1);
    dout_r = 1'b1;
    cyc(1);
    dout_r = 1'b0;
    cyc(10);
    check("bp_gcnt2", gcnt, 9);
    check("bp_npop", pops.size(), 1);
    check("bp_pop0", (pops.size() > 0) ? pops[0] : 32'hX,
          mdata(32'h5000));
    check("bp_addr8", (gaddr.size() > 8) ? gaddr[8] : 32'hX, 32'h5020);
    do_clr();

    // grant stall keeps request and address stable
    tb_gnt = 1'b0;
    dout_r = 1'b1;
    start(32'h2000, 16'd16);
    for (int i = 0; i < 5; i++) begin
      check("st_req", 32'(req.req), 32'd1);
      check("st_addr", req.addr, 32'h2000);
      cyc(1);
    end
    check("st_g0", gcnt, 0);
    tb_gnt = 1'b1;
    cyc(1);
    tb_gnt = 1'b0;
    check("st_g1", gcnt, 1);
    check("st_addr2", req.addr, 32'h2004);
    cyc(3);
    check("st_g1b", gcnt, 1);
    do_clr();

    // clear with three buffered words
    dout_r = 1'b0;
    tb_gnt = 1'b1;
    start(32'h3000, 16'd64);
    begin
      int k = 0;
      while (gcnt < 3 && k < 20) begin
        cyc(1);
        k++;
      end
    end
    tb_gnt = 1'b0;
    check("cl_g3", gcnt, 3);
    cyc(2);
    check("cl_dv", 32'(dout_v), 32'd1);
    check("cl_head", dout, mdata(32'h3000));
    clr = 1'b1;
    cyc(1);
    clr = 1'b0;
    check("cl_dv0", 32'(dout_v), 32'd0);
    check("cl_req0", 32'(req.req), 32'd0);
    check("cl_done0", 32'(done), 32'd0);
    cyc(1);
    check("cl_idle", 32'(req.req), 32'd0);
    clr_stats();
    tb_gnt = 1'b1;
    start(32'h3000, 16'd16);
    check("cl_rq", 32'(req.req), 32'd1);
    check("cl_raddr", req.addr, 32'h3000);
    do_clr();

    // asynchronous reset while draining
    tb_gnt = 1'b1;
    dout_r = 1'b0;
    start(32'h4000, 16'd8);
    cyc(5);
    check("ar_g2", gcnt, 2);
    check("ar_dv", 32'(dout_v), 32'd1);
    check("ar_req", 32'(req.req), 32'd0);
    #2 rst_n = 1'b0;
    #1;
    check("ar_req0", 32'(req.req), 32'd0);
    check("ar_dv0", 32'(dout_v), 32'd0);
    check("ar_done0", 32'(done), 32'd0);
    cyc(1);
    rst_n = 1'b1;
    cyc(2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
